// File: rtl/add_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_pkg
// Description : Shared definitions for the 8-bit bit-serial adder and the
//               driver that sequences it. Holds the operand width, the
//               adder's fixed latency, its bit-inversion keys, its start
//               polarity and the driver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package add_serial_pkg;

    // Operand / result width of the adder.
    localparam int WIDTH = 8;

    // Cycles from the sampled start edge until the adder's out bus is final.
    localparam int ADD_LAT = 10;

    // The adder internally inverts these bit positions on its a/b inputs, so
    // the driver pre-applies the same masks to cancel them.
    localparam logic [7:0] A_KEY = 8'h60;
    localparam logic [7:0] B_KEY = 8'h3E;

    // 1: the adder start input is asserted by driving it low.
    localparam bit EN_ACTIVE_LOW = 1'b1;

    // Driver state encoding.
    localparam int         ST_W     = 2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    // Pin level that expresses a logical start request on the adder en input.
    function automatic logic en_level(input logic active_low, input logic assert_en);
        return assert_en ^ active_low;
    endfunction

endpackage : add_serial_pkg
`default_nettype wire

// File: rtl/add_serial_opfifo.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_opfifo
// Description : Synchronous FIFO for operand pairs. The head entry is shown
//               combinationally on o_head and stays put until popped; when
//               empty the head reads as zero.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push/i_data   - write strobe (ignored when full) and data
//               i_pop           - remove head entry (ignored when empty)
//               o_head          - current head entry
//               o_full/o_empty  - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module add_serial_opfifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4     // power of two, at least 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            w_do_push;
    logic            w_do_pop;
    logic [c_AW-1:0] w_wr_idx;
    logic [c_AW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[c_AW-1:0];
    assign w_rd_idx = r_rd_ptr[c_AW-1:0];

    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) && (w_wr_idx == w_rd_idx);

    // Full blocks a push even when a pop lands in the same cycle: no bypass.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    assign o_head = o_empty ? '0 : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule : add_serial_opfifo
`default_nettype wire

// File: rtl/add_serial_driver.sv
`default_nettype none
// ============================================================================
// Module      : add_serial_driver
// Description : Sequencer wrapped around the bit-serial adder. Buffers operand
//               pairs, presents the key-encoded head pair to the adder, pulses
//               its start input, waits the adder latency, captures the sum and
//               offers it on a valid/ready result port.
// Ports       : clk, rst                  - clock, sync active-high reset
//               op_valid/op_ready/op_a/op_b - operand push interface
//               res_valid/res_ready/res_data - result interface
//               add_a/add_b/add_en        - drive the adder inputs
//               add_out                   - adder sum bus
//               busy                      - operation in flight
// Revision    : 1.0 - initial release
// ============================================================================
module add_serial_driver #(
    parameter int               WIDTH         = add_serial_pkg::WIDTH,
    parameter int               DEPTH         = 4,
    parameter logic [WIDTH-1:0] A_KEY         = add_serial_pkg::A_KEY,
    parameter logic [WIDTH-1:0] B_KEY         = add_serial_pkg::B_KEY,
    parameter bit               EN_ACTIVE_LOW = add_serial_pkg::EN_ACTIVE_LOW,
    parameter int               ADD_LAT       = add_serial_pkg::ADD_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_out,
    output logic             busy
);

    import add_serial_pkg::ST_W;
    import add_serial_pkg::S_IDLE;
    import add_serial_pkg::S_LAUNCH;
    import add_serial_pkg::S_WAIT;
    import add_serial_pkg::en_level;

    localparam int             c_WCNT_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LOAD = c_WCNT_W'(ADD_LAT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ST_W-1:0]     r_state;
    logic                r_primed;     // adder known to sit in its idle state
    logic                r_lcnt;       // start cycles already issued in S_LAUNCH
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_res_valid;
    logic [WIDTH-1:0]    r_res_data;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [2*WIDTH-1:0]  w_head;
    logic [WIDTH-1:0]    w_head_a;
    logic [WIDTH-1:0]    w_head_b;

    assign op_ready = !w_full;
    assign w_push   = op_valid && op_ready;

    // The head is popped only once its sum has been captured, so it stays
    // stable on the adder inputs for the whole launch and wait window.
    assign w_pop    = (r_state == S_WAIT) && (r_wcnt == '0);

    add_serial_opfifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_opfifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({op_a, op_b}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_a = w_head[2*WIDTH-1:WIDTH];
    assign w_head_b = w_head[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Adder-side outputs
    // ------------------------------------------------------------------
    // Pre-inverting with the adder's own keys cancels its internal inversion.
    assign add_a  = w_head_a ^ A_KEY;
    assign add_b  = w_head_b ^ B_KEY;
    assign add_en = en_level(EN_ACTIVE_LOW, r_state == S_LAUNCH);

    // ------------------------------------------------------------------
    // Result-side outputs
    // ------------------------------------------------------------------
    logic w_res_take;

    assign w_res_take = r_res_valid && res_ready;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign busy       = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_primed    <= 1'b1;
            r_lcnt      <= 1'b0;
            r_wcnt      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            if (w_res_take) begin
                r_res_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    // Only one result slot: never start while it is occupied.
                    if (!w_empty && !r_res_valid) begin
                        r_state <= S_LAUNCH;
                        r_lcnt  <= 1'b0;
                    end
                end

                S_LAUNCH: begin
                    // After a completed add the adder parks in DONE and burns
                    // one start cycle getting out of it, hence two cycles then.
                    if (r_primed || r_lcnt) begin
                        r_primed <= 1'b0;
                        r_wcnt   <= c_WCNT_LOAD;
                        r_state  <= S_WAIT;
                    end else begin
                        r_lcnt <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_res_data  <= add_out;
                        r_res_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : add_serial_driver
`default_nettype wire

// File: tb/tb_add_serial_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_serial_driver
// Description : Self-checking bench for add_serial_driver with a behavioural
//               model of the bit-serial adder attached to its adder ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_serial_driver;

    localparam int         LAT = 10;
    localparam logic [7:0] KA  = 8'h60;
    localparam logic [7:0] KB  = 8'h3E;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [7:0] op_a = 8'd0;
    logic [7:0] op_b = 8'd0;
    logic       res_ready = 1'b0;
    logic       op_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_en;
    logic [7:0] add_out;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    add_serial_driver dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_en    (add_en),
        .add_out   (add_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Adder model: decodes its inputs with the keys, and its out bus only
    // carries the true sum from LAT cycles after the last start cycle on
    // (a corrupted value before that). Also logs every start pulse as
    // (last active cycle, pulse length).
    // ------------------------------------------------------------------
    int         cyc = 0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_b = 8'd0;
    logic [7:0] m_sum;
    int         m_cnt = 100;
    bit         prev_act = 1'b0;
    int         run = 0;
    int         q_L[$];
    int         q_len[$];

    assign m_sum   = m_a + m_b;
    assign add_out = (m_cnt >= LAT - 1) ? m_sum : (m_sum ^ 8'h5A);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_a      <= 8'd0;
            m_b      <= 8'd0;
            m_cnt    <= 100;
            prev_act <= 1'b0;
            run      <= 0;
        end else if (add_en == 1'b0) begin
            m_a      <= add_a ^ KA;
            m_b      <= add_b ^ KB;
            m_cnt    <= 0;
            run      <= prev_act ? run + 1 : 1;
            prev_act <= 1'b1;
        end else begin
            if (prev_act) begin
                q_L.push_back(cyc - 1);
                q_len.push_back(run);
            end
            prev_act <= 1'b0;
            if (m_cnt < 1000) m_cnt <= m_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking inside; they report observations)
    // ------------------------------------------------------------------
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, output bit ok);
        int n = 0;
        ok = 1'b0;
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        while (!op_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (op_ready) begin
            @(negedge clk);
            ok = 1'b1;
        end
        op_valid = 1'b0;
    endtask

    task automatic get_launch(output int L, output int len, output bit ok);
        int n = 0;
        L = -1;
        len = -1;
        while (q_L.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (q_L.size() != 0);
        if (ok) begin
            L   = q_L.pop_front();
            len = q_len.pop_front();
        end
    endtask

    task automatic wait_res(output int rc, output logic [7:0] d, output bit ok);
        int n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = res_valid;
        rc = cyc;
        d  = res_data;
        if (ok && res_ready) @(negedge clk);
    endtask

    task automatic one_op(input logic [7:0] a, input logic [7:0] b,
                          output int L, output int len, output int rc,
                          output logic [7:0] d, output bit ok);
        bit ok1, ok2, ok3;
        push_pair(a, b, ok1);
        get_launch(L, len, ok2);
        wait_res(rc, d, ok3);
        ok = ok1 && ok2 && ok3;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (op_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        tests_run++; if (res_data !== 8'd0) begin tests_failed++; $display("FAIL reset_res_data: got %h expected 00", res_data); end
        tests_run++; if (add_en !== 1'b1) begin tests_failed++; $display("FAIL reset_add_en: got %b expected 1", add_en); end
        tests_run++; if (add_a !== 8'h60) begin tests_failed++; $display("FAIL reset_add_a: got %h expected 60", add_a); end
        tests_run++; if (add_b !== 8'h3E) begin tests_failed++; $display("FAIL reset_add_b: got %h expected 3e", add_b); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        q_L.delete();
        q_len.delete();
    endtask

    task automatic test_first_op();
        bit ok, ok2, ok3;
        int n = 0;
        int L, len, rc;
        logic [7:0] d;
        res_ready = 1'b1;
        push_pair(8'd3, 8'd4, ok);
        while (add_en !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++; if (add_en !== 1'b0) begin tests_failed++; $display("FAIL first_start_seen: got %b expected 0", add_en); end
        tests_run++; if (add_a !== 8'h63) begin tests_failed++; $display("FAIL first_add_a: got %h expected 63", add_a); end
        tests_run++; if (add_b !== 8'h3A) begin tests_failed++; $display("FAIL first_add_b: got %h expected 3a", add_b); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL first_busy: got %b expected 1", busy); end
        get_launch(L, len, ok2);
        wait_res(rc, d, ok3);
        tests_run++; if (!(ok && ok2 && ok3)) begin tests_failed++; $display("FAIL first_timeout: got %b%b%b expected 111", ok, ok2, ok3); end
        tests_run++; if (len !== 1) begin tests_failed++; $display("FAIL first_len: got %0d expected 1", len); end
        tests_run++; if (d !== 8'd7) begin tests_failed++; $display("FAIL first_sum: got %0d expected 7", d); end
        tests_run++; if (rc !== L + LAT + 1) begin tests_failed++; $display("FAIL first_latency: got %0d expected %0d", rc, L + LAT + 1); end
    endtask

    task automatic test_second_op();
        bit ok;
        int L, len, rc;
        logic [7:0] d;
        one_op(8'd200, 8'd100, L, len, rc, d, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL second_timeout: got 0 expected 1"); end
        tests_run++; if (len !== 2) begin tests_failed++; $display("FAIL second_len: got %0d expected 2", len); end
        tests_run++; if (d !== 8'd44) begin tests_failed++; $display("FAIL second_sum: got %0d expected 44", d); end
        tests_run++; if (rc !== L + LAT + 1) begin tests_failed++; $display("FAIL second_latency: got %0d expected %0d", rc, L + LAT + 1); end
    endtask

    task automatic test_random();
        bit ok;
        int L, len, rc;
        logic [7:0] a, b, d;
        logic [8:0] s;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s = {1'b0, a} + {1'b0, b};
            one_op(a, b, L, len, rc, d, ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL rand_timeout[%0d]: got 0 expected 1", i); end
            tests_run++; if (len !== 2) begin tests_failed++; $display("FAIL rand_len[%0d]: got %0d expected 2", i, len); end
            tests_run++; if (d !== s[7:0]) begin tests_failed++; $display("FAIL rand_sum[%0d] %0d+%0d: got %0d expected %0d", i, a, b, d, s[7:0]); end
            tests_run++; if (rc !== L + LAT + 1) begin tests_failed++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, rc, L + LAT + 1); end
        end
    endtask

    task automatic test_boundary();
        logic [7:0] av[4] = '{8'd255, 8'd0, 8'd128, 8'd85};
        logic [7:0] bv[4] = '{8'd1,   8'd0, 8'd128, 8'd170};
        logic [7:0] ev[4] = '{8'd0,   8'd0, 8'd0,   8'd255};
        bit ok;
        int L, len, rc;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            one_op(av[i], bv[i], L, len, rc, d, ok);
            tests_run++; if (!ok) begin tests_failed++; $display("FAIL bound_timeout[%0d]: got 0 expected 1", i); end
            tests_run++; if (d !== ev[i]) begin tests_failed++; $display("FAIL bound_sum[%0d] %0d+%0d: got %0d expected %0d", i, av[i], bv[i], d, ev[i]); end
        end
    endtask

    task automatic test_full_stall();
        logic [7:0] exq[$];
        logic [7:0] a, b, d, held;
        logic [8:0] s;
        bit ok, ok2;
        bit stable_ok = 1'b1, idle_ok = 1'b1, quiet_ok = 1'b1;
        int L, len, rc, H;
        res_ready = 1'b0;
        q_L.delete();
        q_len.delete();
        for (int k = 0; k < 4; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s = {1'b0, a} + {1'b0, b};
            op_a = a;
            op_b = b;
            op_valid = 1'b1;
            tests_run++; if (op_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_ready_before[%0d]: got %b expected 1", k, op_ready); end
            exq.push_back(s[7:0]);
            @(negedge clk);
        end
        op_valid = 1'b0;
        tests_run++; if (op_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_full: got %b expected 0", op_ready); end
        get_launch(L, len, ok);
        wait_res(rc, d, ok2);
        held = exq.pop_front();
        tests_run++; if (!(ok && ok2)) begin tests_failed++; $display("FAIL stall_timeout: got %b%b expected 11", ok, ok2); end
        tests_run++; if (d !== held) begin tests_failed++; $display("FAIL stall_first_sum: got %0d expected %0d", d, held); end
        // Hold the result for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            if (res_valid !== 1'b1 || res_data !== held) stable_ok = 1'b0;
            if (busy !== 1'b0) idle_ok = 1'b0;
            if (add_en !== 1'b1 || q_L.size() != 0) quiet_ok = 1'b0;
            @(negedge clk);
        end
        tests_run++; if (!stable_ok) begin tests_failed++; $display("FAIL hold_stable: got %0d/%b expected %0d/1", res_data, res_valid, held); end
        tests_run++; if (!idle_ok) begin tests_failed++; $display("FAIL hold_busy: got %b expected 0", busy); end
        tests_run++; if (!quiet_ok) begin tests_failed++; $display("FAIL hold_no_start: got %0d extra pulses expected 0", q_L.size()); end
        tests_run++; if (op_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_slot_freed: got %b expected 1", op_ready); end
        // Refill to full with a fifth pair.
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        s = {1'b0, a} + {1'b0, b};
        push_pair(a, b, ok);
        exq.push_back(s[7:0]);
        tests_run++; if (op_ready !== 1'b0) begin tests_failed++; $display("FAIL refill_full: got %b expected 0", op_ready); end
        // Handshake at the end of cycle H, then drain.
        H = cyc;
        res_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            get_launch(L, len, ok);
            wait_res(rc, d, ok2);
            if (k == 0) begin
                tests_run++; if (L - len + 1 !== H + 2) begin tests_failed++; $display("FAIL next_launch_cycle: got %0d expected %0d", L - len + 1, H + 2); end
            end
            held = exq.pop_front();
            tests_run++; if (!(ok && ok2)) begin tests_failed++; $display("FAIL drain_timeout[%0d]: got %b%b expected 11", k, ok, ok2); end
            tests_run++; if (d !== held) begin tests_failed++; $display("FAIL drain_sum[%0d]: got %0d expected %0d", k, d, held); end
            tests_run++; if (len !== 2) begin tests_failed++; $display("FAIL drain_len[%0d]: got %0d expected 2", k, len); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, ok1, ok2;
        bit quiet = 1'b1;
        int L, len, rc;
        logic [7:0] d;
        res_ready = 1'b1;
        q_L.delete();
        q_len.delete();
        push_pair(8'd10, 8'd20, ok1);
        push_pair(8'd30, 8'd40, ok2);
        get_launch(L, len, ok);
        repeat (3) @(negedge clk);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (op_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_op_ready: got %b expected 1", op_ready); end
        tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_res_valid: got %b expected 0", res_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
        tests_run++; if (add_a !== 8'h60) begin tests_failed++; $display("FAIL mid_fifo_empty: got add_a %h expected 60", add_a); end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || add_en !== 1'b1) quiet = 1'b0;
        end
        tests_run++; if (!quiet) begin tests_failed++; $display("FAIL mid_no_activity: got activity expected none"); end
        q_L.delete();
        q_len.delete();
        one_op(8'd1, 8'd1, L, len, rc, d, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL mid_op_timeout: got 0 expected 1"); end
        tests_run++; if (len !== 1) begin tests_failed++; $display("FAIL mid_primed_len: got %0d expected 1", len); end
        tests_run++; if (d !== 8'd2) begin tests_failed++; $display("FAIL mid_sum: got %0d expected 2", d); end
        tests_run++; if (rc !== L + LAT + 1) begin tests_failed++; $display("FAIL mid_latency: got %0d expected %0d", rc, L + LAT + 1); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_op();
        test_second_op();
        test_random();
        test_full_stall();
        test_reset_mid();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_add_serial_driver
`default_nettype wire

// File: doc/add_serial_driver.md
Name: add_serial_driver

Overview:
Sequencer placed directly upstream and downstream of the 8-bit bit-serial adder (add_serial). It buffers operand pairs in a small FIFO and pre-encodes each operand with the adder's fixed bit-inversion keys. It drives the adder's a/b/en inputs and waits the adder's fixed latency. It then captures the adder's out bus and presents the sum on a valid/ready result port.

Parameters:
WIDTH, 8, operand and result width; must match the adder.
DEPTH, 4, operand FIFO entries; power of two, at least 2.
A_KEY, 8'h60, XOR mask applied to op_a before it drives add_a.
B_KEY, 8'h3E, XOR mask applied to op_b before it drives add_b.
EN_ACTIVE_LOW, 1, adder start polarity; 1 means add_en is driven 0 to request a start.
ADD_LAT, 10, cycles from the sampled start edge to a stable final add_out.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset; also wired to the adder's rst
op_valid  in  1  operand pair offered
op_ready  out  1  FIFO can accept; equals !full
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
res_valid  out  1  sum available
res_ready  in  1  downstream accepts the sum
res_data  out  WIDTH  (op_a+op_b) mod 2^WIDTH
add_a  out  WIDTH  to adder a; equals head_a ^ A_KEY
add_b  out  WIDTH  to adder b; equals head_b ^ B_KEY
add_en  out  1  to adder en; inactive level is !EN_ACTIVE_LOW
add_out  in  WIDTH  from adder out
busy  out  1  an operation is in flight (state != S_IDLE)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: FIFO empty, op_ready=1, res_valid=0, res_data=0, add_en inactive, add_a=A_KEY, add_b=B_KEY, busy=0, primed=1, state S_IDLE.
- primed flag: 1 means the adder sits in its idle state. Set by rst; cleared after the first launch. After any completed operation the adder parks in DONE, which needs one extra start cycle to leave.
- FIFO push: occurs when op_valid && op_ready. When the FIFO is full, op_ready=0 even if a pop happens in the same cycle; no bypass. Pointers wrap modulo DEPTH.
- FSM states:
  S_IDLE: go to S_LAUNCH when the FIFO is non-empty and res_valid=0 (the single result slot is free).
  S_LAUNCH: add_a/add_b come combinationally from the FIFO head. Drive add_en active for 1 cycle if primed, else 2 cycles; the head stays stable throughout. Then clear primed, load wcnt=ADD_LAT-1, and go to S_WAIT.
  S_WAIT: add_en inactive; head still held. Decrement wcnt each cycle. At wcnt==0, capture res_data<=add_out, pop the FIFO, set res_valid, and go to S_IDLE.
- Capture timing: let L be the last launch cycle. Capture happens at the end of cycle L+ADD_LAT, so res_valid is high from cycle L+ADD_LAT+1.
- Result handshake: res_valid and res_data hold until res_ready. res_valid clears on the handshake edge. The next launch may begin in the cycle after res_valid drops.
- Arithmetic: no carry-out is produced; sums wrap modulo 2^WIDTH.
- Reset mid-operation: state, FIFO and result slot are discarded. The adder is reset by the same rst, so primed=1 is correct.
- rst dominates push and handshake in the same cycle.

Decomposition:
- Shared package add_serial_pkg holds: driver state encoding (S_IDLE, S_LAUNCH, S_WAIT), WIDTH, ADD_LAT, A_KEY, B_KEY and EN_ACTIVE_LOW. The adder and the driver both import it.
- One sub-module: add_serial_opfifo, a synchronous FIFO of width 2*WIDTH, depth DEPTH, with full/empty flags.

Test Plan:
- First operation after reset: op 3+4, res_ready=1 -> add_a=8'h63, add_b=8'h3A, add_en=0 for exactly 1 cycle; res_data=7 with res_valid rising 11 cycles after the launch cycle.
- Second operation: op 200+100 -> add_en=0 for 2 cycles; res_data=44 (wrap) at L+11; primed stays 0.
- Full and stall: push 5 pairs with res_ready=0 -> op_ready=0 after the 4th accepted pair. The first result holds its value and no further add_en pulse occurs. Raising res_ready then drains 4 correct sums in order.
- Held result: hold res_ready=0 for 20 cycles after res_valid -> res_data stable and busy=0. The next launch occurs only the cycle after the handshake.
- Reset mid-operation: assert rst during S_WAIT -> next cycle op_ready=1, res_valid=0, FIFO empty. The following op 1+1 yields 2 using the 1-cycle (primed) launch.
- Boundary sums: 255+1 -> 0; 0+0 -> 0; 128+128 -> 0; 85+170 -> 255.
